// File: rtl/y_sig_compactor.sv
//------------------------------------------------------------------------------
// Module   : y_sig_compactor
// Purpose  : Folds each accepted y sample into a 32-bit MISR signature, one slice
//            per cycle. After N_SAMPLES samples it checks the signature against
//            expect_sig and reports pass/fail.
//            Optional: `define Y_COMPARE_EN adds a direct y/y_ref comparison.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module y_sig_compactor #(
  parameter int                 Y_W       = 605,
  parameter int                 SLICE_W   = 32,
  parameter logic [SLICE_W-1:0] POLY      = 32'h04C11DB7,
  parameter logic [SLICE_W-1:0] SIG_INIT  = 32'hFFFFFFFF,
  parameter int                 N_SAMPLES = 20,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               y_valid,
  output logic               y_ready,
  input  logic [Y_W-1:0]     y,
`ifdef Y_COMPARE_EN
  input  logic [Y_W-1:0]     y_ref,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [CNT_W-1:0]   first_mis_idx,
`endif
  input  logic [SLICE_W-1:0] expect_sig,
  output logic [SLICE_W-1:0] sig,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic               busy,
  output logic               done,
  output logic               pass
);

  localparam int c_NSLICE = (Y_W + SLICE_W - 1) / SLICE_W;
  localparam int c_PAD_W  = c_NSLICE * SLICE_W;
  localparam int c_IDX_W  = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NSLICE - 1);
  localparam logic [CNT_W-1:0]   c_N        = CNT_W'(N_SAMPLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_PAD_W-1:0]   r_y_hold;
  logic [c_PAD_W-1:0]   w_y_pad;
  logic [c_IDX_W-1:0]   r_idx;
  logic [SLICE_W-1:0]   r_sig;
  logic [SLICE_W-1:0]   w_sig_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 r_pass;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_finish;
  logic                 w_sig_ok;

  always_comb begin
    w_y_pad          = '0;
    w_y_pad[Y_W-1:0] = y;
  end

  // r_y_hold shifts down one slice per fold, so the active slice is always the LSBs
  assign w_sig_next = {r_sig[SLICE_W-2:0], 1'b0}
                    ^ (r_sig[SLICE_W-1] ? POLY : '0)
                    ^ r_y_hold[SLICE_W-1:0];
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_finish   = w_last && (w_cnt_inc == c_N);
  assign w_sig_ok   = (w_sig_next == expect_sig);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    y_ready     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        y_ready  = ~start;
        w_accept = y_valid & ~start;
        if (w_accept) w_state_nxt = S_FOLD;
      end
      S_FOLD: begin
        busy = 1'b1;
        if (r_idx == c_LAST_IDX) begin
          w_last      = 1'b1;
          w_state_nxt = (w_cnt_inc == c_N) ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (start) w_state_nxt = S_IDLE;
  end

`ifdef Y_COMPARE_EN
  logic [Y_W-1:0]   r_yref_hold;
  logic [CNT_W-1:0] r_mis_cnt;
  logic [CNT_W-1:0] r_first_mis;
  logic             w_mis_now;
  logic             w_mis_any;

  // The hold register is still unshifted only on the first fold cycle
  assign w_mis_now = busy && (r_idx == '0) && (r_y_hold[Y_W-1:0] != r_yref_hold);
  assign w_mis_any = w_mis_now || (r_mis_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_yref_hold <= '0;
      r_mis_cnt   <= '0;
      r_first_mis <= '1;
    end else if (start) begin
      r_mis_cnt   <= '0;
      r_first_mis <= '1;
    end else begin
      if (w_accept) r_yref_hold <= y_ref;
      if (w_mis_now) begin
        if (r_mis_cnt != '1) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
        if (r_mis_cnt == '0) r_first_mis <= r_cnt;
      end
    end
  end

  assign mismatch_cnt  = r_mis_cnt;
  assign first_mis_idx = r_first_mis;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig    <= SIG_INIT;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_y_hold <= '0;
      r_pass   <= 1'b0;
    end else if (start) begin
      r_sig  <= SIG_INIT;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_pass <= 1'b0;
    end else begin
      if (w_accept) begin
        r_y_hold <= w_y_pad;
        r_idx    <= '0;
      end
      if (busy) begin
        r_sig    <= w_sig_next;
        r_y_hold <= r_y_hold >> SLICE_W;
        r_idx    <= w_last ? '0 : r_idx + c_IDX_W'(1);
        if (w_last) r_cnt <= w_cnt_inc;
      end
`ifdef Y_COMPARE_EN
      if (w_finish) r_pass <= w_sig_ok && !w_mis_any;
`else
      if (w_finish) r_pass <= w_sig_ok;
`endif
    end
  end

  assign sig        = r_sig;
  assign sample_cnt = r_cnt;
  assign pass       = r_pass;

endmodule

`default_nettype wire

// File: doc/y_sig_compactor.md
Name: y_sig_compactor

Overview:
Downstream consumer of the 605-bit `y` bus produced by the generated `top` under test in the equivalence-check simulation flow.
- Accepts one `y` sample per valid/ready handshake.
- Folds each sample, one slice per cycle, into a 32-bit MISR signature.
- After N_SAMPLES samples, compares the signature against an expected value and flags pass/fail.
- Replaces per-cycle `$strobe` dumps with a single compact signature per run, usable in both RTL and netlist simulation.

Parameters:
- Y_W, 605, width of the `y` bus.
- SLICE_W, 32, slice and signature width.
- POLY, 32'h04C11DB7, MISR feedback polynomial.
- SIG_INIT, 32'hFFFFFFFF, signature value after reset or `start`.
- N_SAMPLES, 20, samples per run; must be ≥ 1.
- CNT_W, 16, sample counter width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  synchronous run restart.
- y_valid  in  1  `y` sample offered.
- y_ready  out  1  compactor can accept a sample.
- y  in  Y_W  sample from `top`.
- expect_sig  in  SLICE_W  golden signature, sampled on entry to DONE.
- sig  out  SLICE_W  current signature.
- sample_cnt  out  CNT_W  samples fully folded this run.
- busy  out  1  high in FOLD.
- done  out  1  high in DONE.
- pass  out  1  compare result, valid while `done`.

Behaviour:
- Derived constant: NSLICE = ceil(Y_W/SLICE_W) = 19.
  - Slice k = y_hold[k*SLICE_W +: SLICE_W], k = 0 first.
  - Last slice is zero-extended (bits 604:576 plus 3 zero MSBs).
- Reset (async, rst=1):
  - state = IDLE, sig = SIG_INIT, sample_cnt = 0.
  - busy = 0, done = 0, pass = 0, y_ready = 1 once rst deasserts.
- States and transitions:
  - IDLE: y_ready = ~start. On y_valid & y_ready, capture `y` into y_hold, set slice index = 0, go to FOLD.
  - FOLD: y_ready = 0, busy = 1. Each cycle: sig <= {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ slice[idx], then idx++.
    - After slice NSLICE-1: sample_cnt++.
    - If the new count equals N_SAMPLES, go to DONE, else go to IDLE.
  - DONE: y_ready = 0, done = 1. On entry, pass <= (sig_final == expect_sig), using the post-last-slice signature. Hold until `start`.
- Timing:
  - Handshake at edge T: slices are folded at edges T+1..T+19.
  - IDLE is re-entered (y_ready = 1) after edge T+19.
  - Next accept earliest at edge T+20.
  - Throughput is 1 sample per 20 cycles.
- start (any state, synchronous, highest priority):
  - sig = SIG_INIT, sample_cnt = 0, idx = 0, go to IDLE.
  - done = 0, pass = 0, busy = 0.
  - An in-flight FOLD sample is discarded.
- start together with y_valid in IDLE: y_ready = 0, so no handshake occurs and the sample is not captured.
- y_valid held during FOLD: sample is not taken; it is accepted on the first IDLE cycle.
- y_valid in DONE: ignored.
- sample_cnt never wraps, because DONE is reached at N_SAMPLES.
- rst asserted mid-FOLD: immediate return to reset values; y_hold contents are irrelevant.

Optional Feature:
Macro Y_COMPARE_EN.
- Defined:
  - Adds input y_ref[Y_W-1:0], captured with `y` at the handshake.
  - Adds output mismatch_cnt[CNT_W-1:0], incremented (saturating) in the accept cycle's successor when y_hold != yref_hold.
  - Adds output first_mis_idx[CNT_W-1:0], holding the sample_cnt value of the first mismatching sample; all-ones if none.
  - pass = sig match AND mismatch_cnt == 0.
  - Both new outputs clear on rst/start.
- Undefined: these ports and registers do not exist; pass is signature-only.

Test Plan:
1. rst pulse mid-FOLD (3rd slice) → asynchronously sig = FFFFFFFF, sample_cnt = 0, busy = 0, done = 0, pass = 0; y_ready = 1 after release.
2. SIG_INIT = 0, N_SAMPLES = 1, y = 0, expect_sig = 0 → accept at T, busy on T+1..T+19, done = 1 and sig = 00000000, pass = 1.
3. SIG_INIT = 0, N_SAMPLES = 1, y = 1 (bit 0) → sig = 00040000 (18 shifts after slice 0). expect_sig = 00040000 → pass = 1; expect_sig = 00040001 → pass = 0.
4. SIG_INIT = 0, N_SAMPLES = 1, y = bit 604 only → sig = 10000000 (last slice, no further shift), done = 1.
5. Hold y_valid = 1 continuously with N_SAMPLES = 3 → accepts at T, T+20, T+40; sample_cnt steps 1, 2, 3; done at T+60. Separately, start asserted with y_valid in IDLE → no accept, y_ready = 0 that cycle.
6. Y_COMPARE_EN defined, 4 samples with y_ref == y except sample 2 (bit 300 flipped), correct expect_sig → mismatch_cnt = 1, first_mis_idx = 2, pass = 0.
